// File: rtl/alu_seq_pkg.sv
// Shared opcode constants and the command record buffered ahead of the ALU.
package alu_seq_pkg;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_MAX = OP_XOR;

  // Tag width carried in the buffered command record.
  localparam int CMD_TAG_W = 4;

  typedef struct packed {
    logic [15:0]          a;
    logic [15:0]          b;
    logic [3:0]           op;
    logic [CMD_TAG_W-1:0] tag;
  } cmd_t;
endpackage

// File: rtl/alu_issue_seq_if.sv
// Command-in / result-out handshake bundle of the ALU issue sequencer.
interface alu_issue_seq_if #(parameter int TAG_W = 4);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_a;
  logic [15:0]      in_b;
  logic [3:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic [15:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  modport master (output in_valid, in_a, in_b, in_op, in_tag,
                  input  in_ready, out_valid, out_result, out_tag, out_illegal);
  modport slave  (input  in_valid, in_a, in_b, in_op, in_tag,
                  output in_ready, out_valid, out_result, out_tag, out_illegal);
endinterface

// File: rtl/alu_cmd_fifo.sv
// Command FIFO; space is registered so acceptance never depends on a same-cycle pop.
module alu_cmd_fifo
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  cmd_t                   din,
  input  logic                   pop,
  output cmd_t                   dout,
  output logic                   full,
  output logic                   empty,
  output logic                   space,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;
  logic [CW-1:0] count_nxt;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign count_nxt = count + CW'(do_push) - CW'(do_pop);
  assign dout      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      space  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      space <= (count_nxt != CW'(DEPTH));
    end
  end
endmodule

// File: rtl/alu_issue_seq.sv
// Issues buffered commands to a fixed-latency ALU and returns tagged results in order.
module alu_issue_seq
  import alu_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = CMD_TAG_W,
  parameter int ALU_LAT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  alu_issue_seq_if.slave        bus,
  output logic [15:0]           alu_a,
  output logic [15:0]           alu_b,
  output logic [3:0]            alu_op,
  input  logic [15:0]           alu_result,
  output logic                  busy
);
  localparam int CW = $clog2(DEPTH) + 1;

  cmd_t          in_cmd, head;
  logic          full, empty, space, push, pop;
  logic [CW-1:0] count;

  // Track stage ALU_LAT lines up with the cycle alu_result holds that command.
  logic [ALU_LAT:0]            trk_vld;
  logic [ALU_LAT:0][TAG_W-1:0] trk_tag;
  logic [ALU_LAT:0]            trk_ill;

  logic             out_valid, out_illegal;
  logic [15:0]      out_result;
  logic [TAG_W-1:0] out_tag;

  assign in_cmd = '{a: bus.in_a, b: bus.in_b, op: bus.in_op, tag: CMD_TAG_W'(bus.in_tag)};
  assign push   = bus.in_valid && space && !full;
  assign pop    = !empty;

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (in_cmd),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .space (space),
    .count (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      trk_vld     <= '0;
      trk_tag     <= '0;
      trk_ill     <= '0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_tag     <= '0;
      out_illegal <= 1'b0;
    end else begin
      trk_vld <= {trk_vld[ALU_LAT-1:0], pop};
      if (pop) begin
        alu_a      <= head.a;
        alu_b      <= head.b;
        alu_op     <= head.op;
        trk_tag[0] <= TAG_W'(head.tag);
        trk_ill[0] <= (head.op > OP_MAX);
      end
      for (int i = 1; i <= ALU_LAT; i++) begin
        trk_tag[i] <= trk_tag[i-1];
        trk_ill[i] <= trk_ill[i-1];
      end
      out_valid <= trk_vld[ALU_LAT];
      if (trk_vld[ALU_LAT]) begin
        out_result  <= alu_result;
        out_tag     <= trk_tag[ALU_LAT];
        out_illegal <= trk_ill[ALU_LAT];
      end
    end
  end

  assign busy            = (count != '0) || (|trk_vld);
  assign bus.in_ready    = space;
  assign bus.out_valid   = out_valid;
  assign bus.out_result  = out_result;
  assign bus.out_tag     = out_tag;
  assign bus.out_illegal = out_illegal;
endmodule
